l1_stream_reader: RTL and testbench

- Downstream stage of the convolution/max-pool engine.
- Once the engine has filled the layer-1 result memory (csel=3'b011, 32x32 words, 20-bit, addresses 0..1023), this block reads every word in address order and emits it on a valid/ready stream.
- The stream feeds the next layer or the host.
- Provides prefetch against a 1-cycle-latency memory, a small output FIFO that absorbs backpressure, row/frame markers, and a 32-bit checksum of the streamed words.

---
 rtl/l1_stream_reader_pkg.sv | 10 +
 rtl/l1_sync_fifo.sv | 34 +++
 rtl/l1_stream_reader.sv | 99 +++++++++
 tb/tb_l1_stream_reader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/l1_stream_reader_pkg.sv
// l1_stream_reader_pkg: memory selects, layer-1 geometry and FSM states shared by the stream reader
package l1_stream_reader_pkg;
  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;
  localparam int L1_ROWS  = 32;
  localparam int L1_COLS  = 32;
  localparam int L1_WORDS = L1_ROWS * L1_COLS;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/l1_sync_fifo.sv
// l1_sync_fifo: synchronous FIFO with occupancy count; a read frees a slot for a same-cycle write
module l1_sync_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [W-1:0]         wr_data,
  input  logic                 rd_en,
  output logic [W-1:0]         rd_data,
  output logic [$clog2(D):0]   count,
  output logic                 empty
);
  localparam int PW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [PW:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign count   = wr_ptr - rd_ptr;
  assign empty   = count == '0;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (count != (PW+1)'(D) || do_rd);
  assign rd_data = mem[rd_ptr[PW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[PW-1:0]] <= wr_data;
endmodule

// File: rtl/l1_stream_reader.sv
// l1_stream_reader: streams the layer-1 result memory in address order over valid/ready with
// credit-limited prefetch, row/frame tags and a running checksum
module l1_stream_reader
  import l1_stream_reader_pkg::*;
#(
  parameter int DW         = 20,
  parameter int AW         = 12,
  parameter int N_WORDS    = L1_WORDS,
  parameter int ROW_LEN    = L1_COLS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic [2:0]    csel,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_eol,
  output logic          m_last,
  output logic [31:0]   checksum
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [AW:0] rd_cnt;
  logic pend;
  logic [AW-1:0] pend_idx;
  logic [CW-1:0] count;
  logic [DW+1:0] head;
  logic empty, xfer, credit, tag_eol, tag_last;
  // reads already issued (crd) or returning (pend) will each claim a FIFO slot
  assign credit   = (CW+1)'(count) + (CW+1)'(crd) + (CW+1)'(pend) < (CW+1)'(FIFO_DEPTH);
  assign tag_eol  = (32'(pend_idx) % ROW_LEN) == ROW_LEN - 1;
  assign tag_last = 32'(pend_idx) == N_WORDS - 1;
  assign m_valid  = !empty;
  assign xfer     = m_valid && m_ready;
  assign m_data   = m_valid ? head[DW-1:0] : '0;
  assign m_eol    = m_valid && head[DW];
  assign m_last   = m_valid && head[DW+1];
  assign busy     = state != IDLE;
  l1_sync_fifo #(.W(DW + 2), .D(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pend),
    .wr_data ({tag_last, tag_eol, cdata_rd}),
    .rd_en   (xfer),
    .rd_data (head),
    .count   (count),
    .empty   (empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      csel     <= CSEL_NONE;
      pend     <= 1'b0;
      pend_idx <= '0;
      done     <= 1'b0;
      checksum <= '0;
    end else begin
      done     <= 1'b0;
      pend     <= crd;
      pend_idx <= caddr_rd;
      if (xfer) checksum <= checksum + 32'(m_data);
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          csel     <= CSEL_L1;
          crd      <= 1'b1;
          caddr_rd <= '0;
          rd_cnt   <= (AW+1)'(1);
          checksum <= '0;
        end
        RUN: begin
          crd <= 1'b0;
          if (rd_cnt == (AW+1)'(N_WORDS)) state <= DRAIN;
          else if (credit) begin
            crd      <= 1'b1;
            caddr_rd <= rd_cnt[AW-1:0];
            rd_cnt   <= rd_cnt + 1'b1;
          end
        end
        DRAIN: crd <= 1'b0;
        default: state <= IDLE;
      endcase
      if (xfer && m_last) begin
        state <= IDLE;
        csel  <= CSEL_NONE;
        done  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_l1_stream_reader.sv
// tb_l1_stream_reader: randomized-backpressure bench with an index-based reference of the frame stream
module tb_l1_stream_reader;
  localparam int N = 1024;
  logic clk = 0, reset = 0, start = 0, m_ready = 0;
  logic busy, done, crd, m_valid, m_eol, m_last;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd = '0, m_data, prev_data = '0;
  logic [2:0] csel;
  logic [31:0] checksum, model_sum = '0;
  logic [19:0] mem [N];
  logic done_pend = 0, prev_stall = 0, bubble_chk = 0;
  int checks = 0, errors = 0, mode = 0;
  int issued = 0, accepted = 0, exp_addr = 0, done_cnt = 0;

  always #5 clk = ~clk;

  l1_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_eol(m_eol),
    .m_last(m_last), .checksum(checksum)
  );

  always @(posedge clk) if (crd) cdata_rd <= mem[caddr_rd];

  always @(posedge clk) begin
    #1;
    m_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(99) < 30) : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      issued = 0; accepted = 0; exp_addr = 0; model_sum = 0;
      done_pend = 0; prev_stall = 0;
    end else begin
      if (start && !busy) begin
        issued = 0; accepted = 0; exp_addr = 0; model_sum = 0;
      end
      check("done", done, done_pend);
      if (done) begin
        done_cnt++;
        check("sum_at_done", checksum, model_sum);
        check("busy_at_done", busy, 0);
        check("count_at_done", accepted, N);
      end
      if (crd) begin
        check("addr", caddr_rd, exp_addr);
        exp_addr++;
        issued++;
        check("outstanding_le4", issued - accepted <= 4, 1);
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (bubble_chk && accepted > 0 && accepted < N) check("no_bubble", m_valid, 1);
      if (m_valid && m_ready) begin
        check("in_frame", accepted < N, 1);
        if (accepted < N) begin
          check("data", m_data, mem[accepted]);
          check("eol", m_eol, accepted % 32 == 31);
          check("last", m_last, accepted == N - 1);
        end
        model_sum += 32'(m_data);
        accepted++;
      end
      done_pend = m_valid && m_ready && m_last;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic fill(input int p);
    for (int i = 0; i < N; i++)
      mem[i] = p == 0 ? 20'(i) : p == 1 ? 20'hFFFFF : 20'($urandom);
  endtask

  task automatic check_reset_vals();
    check("rst_ctrl", {busy, done, crd, csel, m_valid, m_eol, m_last}, 0);
    check("rst_addr", caddr_rd, 0);
    check("rst_data", m_data, 0);
    check("rst_sum", checksum, 0);
  endtask

  task automatic pulse_start();
    int lat;
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    check("busy_after_start", busy, 1);
    check("csel_busy", csel, 3'b011);
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    check("first_valid_latency", lat, 3);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt, n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #2;
    check("done_once", done_cnt - d0, 1);
    check("idle_csel", {busy, csel}, 0);
  endtask

  task automatic wait_accepted(input int k);
    int n = 0;
    while (accepted < k && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("reach_word", accepted >= k, 1);
  endtask

  initial begin
    fill(0);
    repeat (3) @(posedge clk);
    #2 check_reset_vals();
    reset = 1;
    bubble_chk = 1;
    pulse_start();
    wait_done(3000);
    bubble_chk = 0;
    check("sum_ramp", checksum, 32'd523776);

    mode = 1;
    pulse_start();
    wait_done(20000);
    check("sum_random_ready", checksum, 32'd523776);

    mode = 2;
    pulse_start();
    repeat (50) @(posedge clk);
    #2;
    check("stall_issued", issued, 4);
    check("stall_crd", crd, 0);
    mode = 0;
    wait_done(3000);
    check("sum_stall", checksum, 32'd523776);

    fill(1);
    pulse_start();
    wait_done(3000);
    check("sum_all_ones", checksum, 32'h3FFFFC00);

    fill(2);
    mode = 1;
    pulse_start();
    wait_accepted(500);
    #2 start = 1;
    @(posedge clk); #2 start = 0;
    wait_done(20000);

    begin
      int d0;
      fill(0);
      mode = 0;
      pulse_start();
      wait_accepted(300);
      d0 = done_cnt;
      #2 reset = 0;
      #1 check_reset_vals();
      repeat (3) @(posedge clk);
      #2 check_reset_vals();
      reset = 1;
      repeat (3) @(posedge clk);
      check("no_partial_done", done_cnt - d0, 0);
      pulse_start();
      wait_done(3000);
      check("sum_after_reset", checksum, 32'd523776);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
